// File: rtl/gf2m8_multiplier.sv
// gf2m8_multiplier
// GF(2^8) multiplier over p(x) = x^8 + x^4 + x^3 + x^2 + 1 (0x11D).
// The combinational product z is for same-cycle use inside processing elements.
// The registered copy z_q, qualified by out_valid, is for pipelined stages.

module gf2m8_multiplier (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] x,
   input  logic [7:0] y,
   output logic [7:0] z,
   input  logic       in_valid,
   output logic [7:0] z_q,
   output logic       out_valid
);

   // Carry-less product of x and y. Bit k is the XOR of every partial product whose exponents sum to k.
   logic [14:0] clProduct;

   // Product after folding bits 14..8 back into the field.
   logic [14:0] reducedProduct;

   // Next-state value for the registered product.
   logic [7:0]  z_d;

   // Next-state value for the registered valid flag.
   logic        out_valid_d;

   // Build the 15-bit carry-less product as an AND plane feeding XOR trees.
   always_comb begin
      clProduct = '0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            clProduct[i + j] = clProduct[i + j] ^ (x[i] & y[j]);
         end
      end
   end

   // Fold from the top bit downwards using x^8 = x^4 + x^3 + x^2 + 1.
   // XOR-ing 0x11D shifted to bit k clears bit k and injects its reduction terms lower down.
   // Every shift is a constant, so this unrolls into a fixed XOR matrix.
   always_comb begin
      reducedProduct = clProduct;
      for (int k = 14; k >= 8; k--) begin
         if (reducedProduct[k]) begin
            reducedProduct = reducedProduct ^ (15'h011D << (k - 8));
         end
      end
   end

   // The combinational output depends only on x and y, never on the registered path.
   assign z = reducedProduct[7:0];

   // Capture a new product only for qualified samples; otherwise hold the last one.
   always_comb begin
      z_d         = z_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         z_d = z;
      end
   end

   // Pipeline register with synchronous reset; the sample presented during reset is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_q       <= 8'h00;
         out_valid <= 1'b0;
      end else begin
         z_q       <= z_d;
         out_valid <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_gf2m8_multiplier.sv
// tb_gf2m8_multiplier
// Scoreboard bench for the GF(2^8) multiplier.
// Combinational products are compared directly against a shift-and-XOR model.
// Registered results are checked by a separate monitor that pops the scoreboard queue.

module tb_gf2m8_multiplier;

   logic       clk;
   logic       rst;
   logic [7:0] x;
   logic [7:0] y;
   logic [7:0] z;
   logic       in_valid;
   logic [7:0] z_q;
   logic       out_valid;

   int         assertCount;
   int         failCount;
   logic [7:0] expectQueue[$];
   logic       expValidQ;

   gf2m8_multiplier dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .y         (y),
      .z         (z),
      .in_valid  (in_valid),
      .z_q       (z_q),
      .out_valid (out_valid)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shift-and-add reference: doubles a with the 0x1D feedback once per bit of b
   function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[7] ? ((sh << 1) ^ 8'h1D) : (sh << 1);
      end
      return acc;
   endfunction

   // Generic comparison that records the result and reports any failure
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge.
   // A qualified sample taken outside reset queues its expected product.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic v, input logic r);
      @(posedge clk);
      #1;
      x        = a;
      y        = b;
      in_valid = v;
      rst      = r;
      if (v && !r) expectQueue.push_back(refMul(a, b));
   endtask

   // Model of out_valid: cleared by reset, otherwise it follows in_valid one cycle late
   always @(posedge clk) begin
      expValidQ <= rst ? 1'b0 : in_valid;
   end

   // Monitor: check out_valid every cycle and pop the scoreboard whenever a result appears
   always @(negedge clk) begin
      assertCount++;
      if (out_valid !== expValidQ) begin
         failCount++;
         $display("[TB] FAIL out_valid at %0t: got %b, expected %b", $time, out_valid, expValidQ);
      end
      if (out_valid === 1'b1) begin
         if (expectQueue.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL z_q unexpected result at %0t: got 0x%02h, expected no output", $time, z_q);
         end else begin
            checkOutput("z_q scoreboard", z_q, expectQueue.pop_front());
         end
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Main stimulus sequence
   initial begin
      logic [7:0] pModel;
      logic [7:0] pDut;
      logic [7:0] aR;
      logic [7:0] bR;

      assertCount = 0;
      failCount   = 0;
      expValidQ   = 1'b0;
      rst         = 1'b1;
      x           = 8'h00;
      y           = 8'h00;
      in_valid    = 1'b1;

      // Reset holds the registered outputs at zero, even with in_valid high
      applyStimulus(8'h03, 8'h03, 1'b1, 1'b1);
      applyStimulus(8'h03, 8'h03, 1'b1, 1'b1);
      #1;
      checkOutput("reset z_q", z_q, 8'h00);
      checkOutput("reset z combinational", z, 8'h05);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);

      // Directed products with hand-computed values, in both operand orders
      x = 8'h03; y = 8'h03; #1; checkOutput("03*03", z, 8'h05);
      x = 8'h02; y = 8'h80; #1; checkOutput("02*80", z, 8'h1D);
      x = 8'h80; y = 8'h02; #1; checkOutput("80*02", z, 8'h1D);
      x = 8'h80; y = 8'h80; #1; checkOutput("80*80", z, 8'h13);
      x = 8'h02; y = 8'h8E; #1; checkOutput("02*8E inverse", z, 8'h01);
      x = 8'h8E; y = 8'h02; #1; checkOutput("8E*02 inverse", z, 8'h01);

      // Identities against zero and one for every x
      for (int a = 0; a < 256; a++) begin
         x = 8'(a); y = 8'h00; #1; checkOutput("x*00", z, 8'h00);
         x = 8'h00; y = 8'(a); #1; checkOutput("00*y", z, 8'h00);
         x = 8'(a); y = 8'h01; #1; checkOutput("x*01", z, 8'(a));
         x = 8'h01; y = 8'(a); #1; checkOutput("01*y", z, 8'(a));
      end

      // Exhaustive sweep against the reference model
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            x = 8'(a);
            y = 8'(b);
            #1;
            checkOutput("sweep", z, refMul(8'(a), 8'(b)));
         end
      end

      // Powers of 0x02: feed the DUT its own output and track the model chain.
      // The order of 0x02 is 255, so the chain reaches 0x01 exactly at step 255.
      pModel = 8'h01;
      pDut   = 8'h01;
      for (int i = 1; i <= 255; i++) begin
         x = pDut;
         y = 8'h02;
         #1;
         pModel = refMul(pModel, 8'h02);
         checkOutput("power chain", z, pModel);
         assertCount++;
         if ((z == 8'h01) != (i == 255)) begin
            failCount++;
            $display("[TB] FAIL power period at step %0d: got 0x%02h, expected one only at step 255", i, z);
         end
         pDut = z;
      end

      // Registered path: capture one product, then hold it while in_valid is low
      applyStimulus(8'h80, 8'h80, 1'b1, 1'b0);
      applyStimulus(8'h05, 8'h07, 1'b0, 1'b0);
      applyStimulus(8'h09, 8'h0B, 1'b0, 1'b0);
      #1;
      checkOutput("z_q hold", z_q, 8'h13);

      // Reset mid-stream: the sample in the reset cycle is dropped, but z stays correct
      applyStimulus(8'h80, 8'h80, 1'b1, 1'b1);
      #1;
      checkOutput("z during reset", z, 8'h13);
      applyStimulus(8'h03, 8'h03, 1'b1, 1'b0);
      #1;
      checkOutput("z_q after mid reset", z_q, 8'h00);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      checkOutput("first post-reset z_q", z_q, 8'h05);

      // Back-to-back streaming of random pairs with no bubbles
      for (int n = 0; n < 256; n++) begin
         aR = 8'($urandom_range(0, 255));
         bR = 8'($urandom_range(0, 255));
         applyStimulus(aR, bR, 1'b1, 1'b0);
      end
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // Every queued result must have been consumed
      assertCount++;
      if (expectQueue.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard drain: got %0d pending results, expected 0", expectQueue.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
